mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory/MIO port between pipeline instruction fetch (IF) and load/store (MEM).
//  It sequences each access over the ready-handshaked bus and returns read data to the winner.
//  It produces the pipeline stall while either requester is waiting.
//  It sits between the pipelined CPU core and the MIO bus. Its bus-side ports supply the core's
//  Addr_out/Data_out/mem_w/CPU_MIO/MIO_ready.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MAX_WAIT    15  BUSY cycles without bus_ready before the access is aborted (>=1)
//  STARVE_LIM  4   consecutive lost arbitrations after which IF wins (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  if_req       in   1       fetch request; held until if_gnt
//  if_addr      in   ADDR_W  fetch address (PC)
//  if_gnt       out  1       1-cycle pulse: fetch complete, if_rdata valid
//  if_rdata     out  DATA_W  fetched instruction
//  mem_req      in   1       load/store request; held until mem_gnt
//  mem_we       in   1       1=store, 0=load
//  mem_addr     in   ADDR_W  data address
//  mem_wdata    in   DATA_W  store data
//  mem_gnt      out  1       1-cycle pulse: access complete
//  mem_rdata    out  DATA_W  load data
//  bus_addr     out  ADDR_W  bus address
//  bus_wdata    out  DATA_W  bus write data
//  bus_we       out  1       bus write strobe
//  bus_sel      out  1       1=data access (MEM owner), 0=fetch
//  bus_rdata    in   DATA_W  bus read data
//  bus_ready    in   1       bus completes current access this cycle
//  stall        out  1       pipeline freeze
//  timeout_err  out  1       sticky abort flag
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state IDLE; all outputs 0; wait_cnt=0, starve_cnt=0; timeout_err cleared.
//  - FSM states IDLE, BUSY_IF, BUSY_MEM. All bus outputs and gnt/rdata are registered.
//  - IDLE arbitration: qualified request = x_req & ~x_gnt. A req seen in its own gnt cycle is ignored.
//    Winner is MEM if mem_req is qualified, unless if_req is qualified and starve_cnt==STARVE_LIM.
//    Otherwise winner is IF if if_req is qualified. If neither, stay IDLE.
//    At the edge: latch bus_addr/bus_wdata/bus_we/bus_sel from the winner; wait_cnt=0.
//  - starve_cnt: +1 when IF qualified but MEM wins (saturates at STARVE_LIM); cleared on IF win.
//  - BUSY_x: bus outputs stable. bus_we=mem_we only in BUSY_MEM. bus_ready is sampled every cycle.
//    On bus_ready=1: x_gnt=1 next cycle; x_rdata<=bus_rdata (not updated for stores); -> IDLE.
//    Else wait_cnt+1. Reaching MAX_WAIT: x_gnt=1, x_rdata<=0, timeout_err<=1, -> IDLE.
//  - Entering IDLE: bus_we=0, bus_sel=0. bus_addr/bus_wdata hold their last value.
//    bus_ready in IDLE is ignored.
//  - Latency: request at cycle 0 -> bus driven cycle 1 -> ready in cycle k>=1 -> gnt in cycle k+1.
//    Minimum is 2 cycles. One IDLE cycle between accesses (gnt cycle).
//  - gnt is high for exactly 1 cycle. if_gnt and mem_gnt are never both 1.
//  - stall = (if_req & ~if_gnt) | (mem_req & ~mem_gnt), combinational.
//  - Requests change mid-BUSY: ignored until the next IDLE. The latched address/data are used.
//  - timeout_err is cleared only by reset.
// TESTING
//  1 Assert rst=0 mid BUSY_MEM store -> bus_we, bus_sel, gnt, stall(with reqs 0) all 0
//    immediately. After release, state is IDLE.
//  2 if_req, if_addr=0x0000_0040, bus_ready=1, bus_rdata=0x2008_0005 -> bus_addr=0x40 in cycle 1.
//    if_gnt=1 and if_rdata=0x20080005 in cycle 2. stall=1 in cycles 0-1, 0 in cycle 2.
//  3 if_req and mem_req both held (mem re-requests after each gnt), STARVE_LIM=4 -> 4 MEM grants,
//    then if_gnt on the 5th arbitration. starve_cnt then reads 0.
//  4 Store mem_addr=0xE000_0000, mem_wdata=0xA5A5_A5A5, bus_ready first high in cycle 4 ->
//    bus_we=bus_sel=1 in cycles 1-4. mem_gnt pulses in cycle 5. mem_rdata unchanged.
//  5 Load with bus_ready=0 forever, MAX_WAIT=15 -> mem_gnt pulses after 15 BUSY cycles.
//    mem_rdata=0. timeout_err=1 and stays 1 through later accesses.
//  6 if_req kept high in the if_gnt cycle with mem_req=0 -> no new access that cycle.
//    Re-grant starts the cycle after.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core-side requesters, the MIO bus and the memory port arbiter.
// The arbiter uses the slave modport; the core/bus environment uses the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;

  // Shared MIO bus
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic              bus_sel;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  // Pipeline status
  logic              stall;
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, bus_ready,
    output if_gnt, if_rdata, mem_gnt, mem_rdata,
    output bus_addr, bus_wdata, bus_we, bus_sel, stall, timeout_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, bus_rdata, bus_ready,
    input  if_gnt, if_rdata, mem_gnt, mem_rdata,
    input  bus_addr, bus_wdata, bus_we, bus_sel, stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one ready-handshaked MIO port between instruction fetch (IF)
// and load/store (MEM). MEM normally has priority; IF wins once it has lost STARVE_LIM
// arbitrations in a row. Accesses that see no bus_ready for MAX_WAIT busy cycles are
// aborted with zero read data and a sticky timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave p
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t            state_q;
  logic [WW-1:0]     wait_cnt_q;
  logic [SW-1:0]     starve_cnt_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_we_q;
  logic              bus_sel_q;
  logic              if_gnt_q;
  logic              mem_gnt_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              timeout_q;

  // A request is not eligible in the cycle its own grant is being presented.
  logic if_qual;
  logic mem_qual;
  logic starved;
  logic pick_mem;
  logic pick_if;

  assign if_qual  = p.if_req  & ~if_gnt_q;
  assign mem_qual = p.mem_req & ~mem_gnt_q;
  assign starved  = (starve_cnt_q == STARVE_MAX);
  assign pick_mem = mem_qual & ~(if_qual & starved);
  assign pick_if  = if_qual & ~pick_mem;

  // Arbitration FSM: all bus-side outputs, grants and read data are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= 1'b0;
      if_gnt_q     <= 1'b0;
      mem_gnt_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      // Grants are single-cycle pulses unless re-asserted below.
      if_gnt_q  <= 1'b0;
      mem_gnt_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_mem) begin
            state_q     <= BUSY_MEM;
            bus_addr_q  <= p.mem_addr;
            bus_wdata_q <= p.mem_wdata;
            bus_we_q    <= p.mem_we;
            bus_sel_q   <= 1'b1;
            wait_cnt_q  <= '0;
            // IF lost this round; count towards forcing it through next time.
            if (if_qual && !starved) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end else if (pick_if) begin
            // Fetches carry no write data, so bus_wdata keeps its last value.
            state_q      <= BUSY_IF;
            bus_addr_q   <= p.if_addr;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= 1'b0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (p.bus_ready) begin
            state_q   <= IDLE;
            bus_we_q  <= 1'b0;
            bus_sel_q <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_gnt_q   <= 1'b1;
              if_rdata_q <= p.bus_rdata;
            end else begin
              mem_gnt_q <= 1'b1;
              // Stores leave the previous load data visible.
              if (!bus_we_q) begin
                mem_rdata_q <= p.bus_rdata;
              end
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Abort: release the requester with zero data and flag the error.
            state_q   <= IDLE;
            bus_we_q  <= 1'b0;
            bus_sel_q <= 1'b0;
            timeout_q <= 1'b1;
            if (state_q == BUSY_IF) begin
              if_gnt_q   <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              mem_gnt_q   <= 1'b1;
              mem_rdata_q <= '0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_we_q  <= 1'b0;
          bus_sel_q <= 1'b0;
        end
      endcase
    end
  end

  assign p.bus_addr    = bus_addr_q;
  assign p.bus_wdata   = bus_wdata_q;
  assign p.bus_we      = bus_we_q;
  assign p.bus_sel     = bus_sel_q;
  assign p.if_gnt      = if_gnt_q;
  assign p.mem_gnt     = mem_gnt_q;
  assign p.if_rdata    = if_rdata_q;
  assign p.mem_rdata   = mem_rdata_q;
  assign p.timeout_err = timeout_q;

  // The pipeline freezes while any requester is still waiting for its grant.
  assign p.stall = (p.if_req & ~if_gnt_q) | (p.mem_req & ~mem_gnt_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for single fetch, load and
// store transactions, plus hand-written sequences for grant-cycle re-requests, starvation,
// timeout and asynchronous reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_WAIT   = 15;
  localparam int STARVE_LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p  (bus_if)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        e_if_gnt;
    logic        e_mem_gnt;
    logic [31:0] e_bus_addr;
    logic [31:0] e_bus_wdata;
    logic        e_bus_we;
    logic        e_bus_sel;
    logic        e_stall;
    logic [31:0] e_if_rdata;
    logic [31:0] e_mem_rdata;
  } vec_t;

  vec_t vecs[$];
  int n_pass  = 0;
  int n_total = 0;
  int both_gnt = 0;

  // Grants must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (bus_if.if_gnt && bus_if.mem_gnt) both_gnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = 32'h0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = 32'h0;
    bus_if.mem_wdata = 32'h0;
    bus_if.bus_rdata = 32'h0;
    bus_if.bus_ready = 1'b0;
  endtask

  initial begin
    int  n_mem;
    int  cyc;
    int  gnt_cyc;
    bit  done;
    bit  early_tmo;

    // Fetch at 0x40, then a load, then a store with ready first seen in its 4th busy cycle.
    //                ifr   if_addr     mr    mwe   mem_addr      mem_wdata     bus_rdata     rdy     eig   emg   bus_addr      bus_wdata     we    sel   stall if_rdata      mem_rdata
    vecs.push_back('{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,        32'h0,        32'h20080005, 1'b1,   1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,        32'h0,        32'h20080005, 1'b1,   1'b0, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'h40,     1'b0, 1'b0, 32'h0,        32'h0,        32'h20080005, 1'b1,   1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 1'b0, 32'h20080005, 32'h0});
    vecs.push_back('{1'b0, 32'h40,     1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0,   1'b0, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 1'b0, 32'h20080005, 32'h0});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b0, 32'h100,      32'h0,        32'h12345678, 1'b1,   1'b0, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 1'b1, 32'h20080005, 32'h0});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b0, 32'h100,      32'h0,        32'h12345678, 1'b1,   1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 1'b1, 1'b1, 32'h20080005, 32'h0});
    vecs.push_back('{1'b0, 32'h0,      1'b0, 1'b0, 32'h100,      32'h0,        32'h12345678, 1'b0,   1'b0, 1'b1, 32'h100,      32'h0,        1'b0, 1'b0, 1'b0, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0,   1'b0, 1'b0, 32'h100,      32'h0,        1'b0, 1'b0, 1'b1, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0,   1'b0, 1'b0, 32'hE0000000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0,   1'b0, 1'b0, 32'hE0000000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0,   1'b0, 1'b0, 32'hE0000000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b1, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1,   1'b0, 1'b0, 32'hE0000000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0,   1'b0, 1'b1, 32'hE0000000, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h20080005, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0,   1'b0, 1'b0, 32'hE0000000, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h20080005, 32'h12345678});

    // Reset state
    idle_inputs();
    #12;
    chk("rst.bus_addr",  bus_if.bus_addr, 32'h0);
    chk("rst.bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst.bus_we",    32'(bus_if.bus_we), 32'h0);
    chk("rst.bus_sel",   32'(bus_if.bus_sel), 32'h0);
    chk("rst.gnts",      32'({bus_if.if_gnt, bus_if.mem_gnt}), 32'h0);
    chk("rst.rdata",     bus_if.if_rdata | bus_if.mem_rdata, 32'h0);
    chk("rst.stall",     32'(bus_if.stall), 32'h0);
    chk("rst.timeout",   32'(bus_if.timeout_err), 32'h0);
    step();
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.if_req    = vecs[i].if_req;
      bus_if.if_addr   = vecs[i].if_addr;
      bus_if.mem_req   = vecs[i].mem_req;
      bus_if.mem_we    = vecs[i].mem_we;
      bus_if.mem_addr  = vecs[i].mem_addr;
      bus_if.mem_wdata = vecs[i].mem_wdata;
      bus_if.bus_rdata = vecs[i].bus_rdata;
      bus_if.bus_ready = vecs[i].bus_ready;
      #1;
      chk($sformatf("v%0d.if_gnt", i),    32'(bus_if.if_gnt),    32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d.mem_gnt", i),   32'(bus_if.mem_gnt),   32'(vecs[i].e_mem_gnt));
      chk($sformatf("v%0d.bus_addr", i),  bus_if.bus_addr,       vecs[i].e_bus_addr);
      chk($sformatf("v%0d.bus_wdata", i), bus_if.bus_wdata,      vecs[i].e_bus_wdata);
      chk($sformatf("v%0d.bus_we", i),    32'(bus_if.bus_we),    32'(vecs[i].e_bus_we));
      chk($sformatf("v%0d.bus_sel", i),   32'(bus_if.bus_sel),   32'(vecs[i].e_bus_sel));
      chk($sformatf("v%0d.stall", i),     32'(bus_if.stall),     32'(vecs[i].e_stall));
      chk($sformatf("v%0d.if_rdata", i),  bus_if.if_rdata,       vecs[i].e_if_rdata);
      chk($sformatf("v%0d.mem_rdata", i), bus_if.mem_rdata,      vecs[i].e_mem_rdata);
      step();
    end
    idle_inputs();
    chk("tbl.timeout", 32'(bus_if.timeout_err), 32'h0);

    // if_req held through its grant cycle: the next fetch starts one cycle later
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h200;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h11110000;
    step();
    step();
    chk("rg.c2.if_gnt", 32'(bus_if.if_gnt), 32'h1);
    chk("rg.c2.if_rdata", bus_if.if_rdata, 32'h11110000);
    bus_if.if_addr = 32'h300; bus_if.bus_rdata = 32'h22220000;
    step();
    #1;
    chk("rg.c3.if_gnt", 32'(bus_if.if_gnt), 32'h0);
    chk("rg.c3.bus_addr", bus_if.bus_addr, 32'h200);
    chk("rg.c3.stall", 32'(bus_if.stall), 32'h1);
    step();
    chk("rg.c4.bus_addr", bus_if.bus_addr, 32'h300);
    chk("rg.c4.if_gnt", 32'(bus_if.if_gnt), 32'h0);
    step();
    chk("rg.c5.if_gnt", 32'(bus_if.if_gnt), 32'h1);
    chk("rg.c5.if_rdata", bus_if.if_rdata, 32'h22220000);
    idle_inputs();
    step();

    // Starvation: MEM keeps winning until IF has lost STARVE_LIM times
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hCAFE0001;
    bus_if.if_addr = 32'h800; bus_if.mem_addr = 32'h900;
    n_mem = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 60) begin
      if (bus_if.if_gnt) begin
        chk("stv.starve_cnt", 32'(dut.starve_cnt_q), 32'h0);
        bus_if.if_req = 1'b0;
        bus_if.mem_req = 1'b0;
        done = 1'b1;
      end else begin
        if (bus_if.mem_gnt) n_mem++;
        bus_if.if_req = ~bus_if.mem_gnt;
        bus_if.mem_req = 1'b1;
      end
      step();
      cyc++;
    end
    chk("stv.if_granted", 32'(done), 32'h1);
    chk("stv.mem_grants", 32'(n_mem), 32'(STARVE_LIM));
    idle_inputs();
    step();

    // Timeout: a load never sees bus_ready
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h400;
    step();
    gnt_cyc = 0; early_tmo = 1'b0; cyc = 1;
    while (gnt_cyc == 0 && cyc < 40) begin
      if (bus_if.mem_gnt) gnt_cyc = cyc;
      else begin
        if (bus_if.timeout_err) early_tmo = 1'b1;
        step();
        cyc++;
      end
    end
    chk("tmo.gnt_cycle", 32'(gnt_cyc), 32'(MAX_WAIT + 1));
    chk("tmo.early_flag", 32'(early_tmo), 32'h0);
    chk("tmo.mem_rdata", bus_if.mem_rdata, 32'h0);
    chk("tmo.flag", 32'(bus_if.timeout_err), 32'h1);
    idle_inputs();
    step();
    chk("tmo.gnt_pulse", 32'(bus_if.mem_gnt), 32'h0);
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'hA00;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h0BADF00D;
    step();
    step();
    chk("tmo.later_if_gnt", 32'(bus_if.if_gnt), 32'h1);
    chk("tmo.later_rdata", bus_if.if_rdata, 32'h0BADF00D);
    chk("tmo.sticky", 32'(bus_if.timeout_err), 32'h1);
    idle_inputs();
    step();

    // Asynchronous reset in the middle of a store
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1;
    bus_if.mem_addr = 32'h500; bus_if.mem_wdata = 32'h55;
    step();
    step();
    chk("ar.pre_we", 32'(bus_if.bus_we), 32'h1);
    chk("ar.pre_sel", 32'(bus_if.bus_sel), 32'h1);
    #3;
    rst = 1'b0;
    bus_if.if_req = 1'b0; bus_if.mem_req = 1'b0;
    #1;
    chk("ar.bus_we", 32'(bus_if.bus_we), 32'h0);
    chk("ar.bus_sel", 32'(bus_if.bus_sel), 32'h0);
    chk("ar.gnts", 32'({bus_if.if_gnt, bus_if.mem_gnt}), 32'h0);
    chk("ar.stall", 32'(bus_if.stall), 32'h0);
    chk("ar.bus_addr", bus_if.bus_addr, 32'h0);
    chk("ar.timeout", 32'(bus_if.timeout_err), 32'h0);
    step();
    rst = 1'b1;
    idle_inputs();
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h600;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h77;
    step();
    chk("ar.post_bus_addr", bus_if.bus_addr, 32'h600);
    chk("ar.post_sel", 32'(bus_if.bus_sel), 32'h0);
    step();
    chk("ar.post_if_gnt", 32'(bus_if.if_gnt), 32'h1);
    chk("ar.post_if_rdata", bus_if.if_rdata, 32'h77);
    idle_inputs();
    step();

    chk("excl.both_gnt", 32'(both_gnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
